// File: rtl/video_pkg.sv
// Shared definitions for the parametrised raster timing generator.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: mode encodings, standard timing sets, the aligned pipeline
// payload type and the colour bit-replication helper.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_SRC   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    localparam int CNT_W      = 12;
    localparam int TILE_IDX_W = 11;

    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_sync_start;
        logic [CNT_W-1:0] h_sync_end;
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_sync_start;
        logic [CNT_W-1:0] v_sync_end;
        logic [CNT_W-1:0] v_total;
    } timing_t;

    localparam timing_t TIMING_640X480_60 = '{
        12'd640,  12'd656,  12'd752,  12'd800,  12'd480,  12'd490,  12'd492,  12'd525};
    localparam timing_t TIMING_800X600_72 = '{
        12'd800,  12'd856,  12'd976,  12'd1040, 12'd600,  12'd637,  12'd643,  12'd666};
    localparam timing_t TIMING_1280X720_60 = '{
        12'd1280, 12'd1390, 12'd1430, 12'd1650, 12'd720,  12'd725,  12'd730,  12'd750};
    localparam timing_t TIMING_1920X1080_60 = '{
        12'd1920, 12'd2008, 12'd2052, 12'd2200, 12'd1080, 12'd1084, 12'd1089, 12'd1125};

    // Everything that must stay aligned with the pixel source's read latency.
    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        blank;
        mode_e       mode;
        logic [23:0] rgb;
    } pipe_t;

    // Widen a 'bits'-wide component to 8 bits by repeating its bit pattern,
    // so full scale maps to 0xFF and zero stays 0x00.
    function automatic logic [7:0] expand_color(input logic [7:0] val, input int bits);
        logic [7:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            idx        = 3'(bits - 1 - (i % bits));
            res[7 - i] = val[idx];
        end
        return res;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-source link: tile-grid request out, source pixel back.
// Latency: source returns pix_* a fixed number of cycles after tile indices.
// Backpressure: none; the source must keep up with the pixel clock.
//
// master = timing generator, slave = image-processing pixel source.
interface video_timing_gen_if #(
    parameter int COLOR_BITS = 4
);
    logic [10:0]           tile_row_o;
    logic [10:0]           tile_col_o;
    logic                  pix_req_o;
    logic                  frame_start_o;
    logic                  line_start_o;
    logic [COLOR_BITS-1:0] pix_r_i;
    logic [COLOR_BITS-1:0] pix_g_i;
    logic [COLOR_BITS-1:0] pix_b_i;

    modport master (
        output tile_row_o, tile_col_o, pix_req_o, frame_start_o, line_start_o,
        input  pix_r_i, pix_g_i, pix_b_i
    );

    modport slave (
        input  tile_row_o, tile_col_o, pix_req_o, frame_start_o, line_start_o,
        output pix_r_i, pix_g_i, pix_b_i
    );
endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth shift register used to align timing with the source latency.
// Latency: DEPTH cycles (DEPTH=0 is a wire).
// Backpressure: none; shifts every cycle.
//
// Ports: i_clk, i_rst (async active-high, loads RST_VAL), i_dat -> o_dat.
module video_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_dat = i_dat;
        end else begin : g_shift
            logic [WIDTH-1:0] r_sr [DEPTH];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
                end else begin
                    r_sr[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_dat = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing + tile-grid indexing + test patterns for the HDMI/DVI encoder.
// Latency: PIX_LATENCY+1 cycles from h/v counters to registered vga_* outputs.
// Backpressure: none; free-running at the pixel clock.
//
// Ports: clk_i/rst_i; mode_i/solid_rgb_i (latched at frame start);
// src (master) carries tile indices, pix_req, frame/line pulses out and the
// source pixel back; vga_* drive the encoder.
module video_timing_gen #(
    parameter int H_ACTIVE     = 1920,
    parameter int H_SYNC_START = 2008,
    parameter int H_SYNC_END   = 2052,
    parameter int H_TOTAL      = 2200,
    parameter int V_ACTIVE     = 1080,
    parameter int V_SYNC_START = 1084,
    parameter int V_SYNC_END   = 1089,
    parameter int V_TOTAL      = 1125,
    parameter int TILE_W       = 120,
    parameter int TILE_H       = 90,
    parameter int PIX_LATENCY  = 1,
    parameter int COLOR_BITS   = 4,
    parameter bit SYNC_POL     = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                mode_i,
    input  logic [23:0]               solid_rgb_i,
    video_timing_gen_if.master        src,
    output logic [7:0]                vga_red_o,
    output logic [7:0]                vga_green_o,
    output logic [7:0]                vga_blue_o,
    output logic                      vga_blank_o,
    output logic                      vga_hsync_o,
    output logic                      vga_vsync_o
);
    import video_pkg::*;

    localparam logic [11:0] HA_M1 = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HA    = 12'(H_ACTIVE);
    localparam logic [11:0] HSS   = 12'(H_SYNC_START);
    localparam logic [11:0] HSE   = 12'(H_SYNC_END);
    localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
    localparam logic [11:0] VA_M1 = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VA    = 12'(V_ACTIVE);
    localparam logic [11:0] VSS   = 12'(V_SYNC_START);
    localparam logic [11:0] VSE   = 12'(V_SYNC_END);
    localparam logic [11:0] VT_M1 = 12'(V_TOTAL - 1);
    localparam logic [11:0] TW_M1 = 12'(TILE_W - 1);
    localparam logic [11:0] TH_M1 = 12'(TILE_H - 1);
    localparam logic [11:0] BW_M1 = 12'(H_ACTIVE / 8 - 1);

    localparam pipe_t PIPE_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, blank: 1'b1,
                                    mode: MODE_SRC, rgb: 24'h0};

    // Stage-0 state. r_run holds the counters at 0 for the first clock after
    // reset so that clock is the frame_start cycle for h=0, v=0.
    logic        r_run;
    logic [11:0] r_h, r_v, r_tx, r_ty, r_bar_cnt;
    logic [10:0] r_col, r_row;
    logic [2:0]  r_bar;
    mode_e       r_mode;
    logic [23:0] r_solid;

    logic        w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_active, w_frame_start;
    mode_e       w_mode;
    logic [23:0] w_solid, w_pat;
    pipe_t       w_s0, w_dl;

    logic [7:0]  r_red, r_green, r_blue;
    logic        r_blank, r_hsync, r_vsync;

    assign w_h_wrap      = (r_h == HT_M1);
    assign w_v_wrap      = (r_v == VT_M1);
    assign w_h_act       = (r_h < HA);
    assign w_v_act       = (r_v < VA);
    assign w_active      = w_h_act && w_v_act;
    assign w_frame_start = r_run && (r_h == 12'd0) && (r_v == 12'd0);

    assign src.frame_start_o = w_frame_start;
    assign src.line_start_o  = r_run && (r_h == 12'd0);
    assign src.pix_req_o     = r_run && w_active;
    assign src.tile_col_o    = r_col;
    assign src.tile_row_o    = r_row;

    // The new mode applies from the frame-start pixel itself, not one later.
    assign w_mode  = w_frame_start ? mode_e'(mode_i) : r_mode;
    assign w_solid = w_frame_start ? solid_rgb_i : r_solid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_run <= 1'b0;  r_h <= '0;   r_v <= '0;   r_tx <= '0;  r_ty <= '0;
            r_col <= '0;    r_row <= '0; r_bar_cnt <= '0; r_bar <= '0;
            r_mode <= MODE_SRC;  r_solid <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else begin
            if (w_frame_start) begin
                r_mode  <= mode_e'(mode_i);
                r_solid <= solid_rgb_i;
            end
            r_h <= w_h_wrap ? 12'd0 : r_h + 12'd1;
            if (w_h_wrap) r_v <= w_v_wrap ? 12'd0 : r_v + 12'd1;

            // Column tile and colour-bar tracking restart at the end of the
            // active part of every line.
            if (w_h_wrap || r_h == HA_M1) begin
                r_tx <= '0;  r_col <= '0;  r_bar_cnt <= '0;  r_bar <= '0;
            end else if (w_h_act) begin
                if (r_tx == TW_M1) begin
                    r_tx  <= '0;
                    r_col <= r_col + 11'd1;
                end else begin
                    r_tx  <= r_tx + 12'd1;
                end
                // Bar 7 absorbs any remainder pixels.
                if (r_bar_cnt == BW_M1) begin
                    r_bar_cnt <= '0;
                    if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 12'd1;
                end
            end

            if (w_h_wrap) begin
                if (r_v == VA_M1 || w_v_wrap) begin
                    r_ty <= '0;  r_row <= '0;
                end else if (w_v_act) begin
                    if (r_ty == TH_M1) begin
                        r_ty  <= '0;
                        r_row <= r_row + 11'd1;
                    end else begin
                        r_ty  <= r_ty + 12'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_pat = '0;
        case (w_mode)
            MODE_BARS:  w_pat = {{8{r_bar[2]}}, {8{r_bar[1]}}, {8{r_bar[0]}}};
            MODE_SOLID: w_pat = w_solid;
            MODE_CHECK: w_pat = {24{r_row[0] ^ r_col[0]}};
            default:    w_pat = '0;
        endcase
    end

    // Until the first post-reset clock the stage-0 word looks like reset so
    // no stale pixel enters the delay line.
    always_comb begin
        w_s0       = PIPE_IDLE;
        w_s0.mode  = w_mode;
        w_s0.rgb   = w_pat;
        if (r_run) begin
            w_s0.hsync = ((r_h >= HSS) && (r_h < HSE)) ^ ~SYNC_POL;
            w_s0.vsync = ((r_v >= VSS) && (r_v < VSE)) ^ ~SYNC_POL;
            w_s0.blank = ~w_active;
        end
    end

    video_delay_line #(
        .WIDTH   ($bits(pipe_t)),
        .DEPTH   (PIX_LATENCY),
        .RST_VAL (PIPE_IDLE)
    ) u_align (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_dat (w_s0),
        .o_dat (w_dl)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hsync <= ~SYNC_POL;  r_vsync <= ~SYNC_POL;  r_blank <= 1'b1;
            r_red   <= '0;         r_green <= '0;         r_blue  <= '0;
        end else begin
            r_hsync <= w_dl.hsync;
            r_vsync <= w_dl.vsync;
            r_blank <= w_dl.blank;
            if (w_dl.blank) begin
                {r_red, r_green, r_blue} <= '0;
            end else if (w_dl.mode == MODE_SRC) begin
                r_red   <= expand_color(8'(src.pix_r_i), COLOR_BITS);
                r_green <= expand_color(8'(src.pix_g_i), COLOR_BITS);
                r_blue  <= expand_color(8'(src.pix_b_i), COLOR_BITS);
            end else begin
                {r_red, r_green, r_blue} <= w_dl.rgb;
            end
        end
    end

    assign vga_red_o   = r_red;
    assign vga_green_o = r_green;
    assign vga_blue_o  = r_blue;
    assign vga_blank_o = r_blank;
    assign vga_hsync_o = r_hsync;
    assign vga_vsync_o = r_vsync;

endmodule
